// File: rtl/debug_dump_receiver_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debug_dump_receiver_if : TX command FIFO and RX dump FIFO handshake bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface debug_dump_receiver_if;
  logic       txFull;
  logic       txWrite;
  logic [7:0] txData;
  logic       rxDataAvailable;
  logic [7:0] rxData;
  logic       rxRead;

  modport master (
    input  txFull, rxDataAvailable, rxData,
    output txWrite, txData, rxRead
  );

  modport slave (
    output txFull, rxDataAvailable, rxData,
    input  txWrite, txData, rxRead
  );
endinterface
`default_nettype wire

// File: rtl/debug_dump_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debug_dump_receiver : issues debug commands and captures the returned dump
// Revision: 1.0
// ----------------------------------------------------------------------------
module debug_dump_receiver #(
  parameter int FRAME_BYTES    = 95,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 7
) (
  input  wire logic               clock,
  input  wire logic               reset,
  input  wire logic               i_cmdStart,
  input  wire logic [1:0]         i_cmdCode,
  input  wire logic               i_abort,
  debug_dump_receiver_if.master   bus,
  input  wire logic [CNT_W-1:0]   i_rdAddr,
  output logic      [7:0]         o_rdData,
  output logic      [CNT_W-1:0]   o_byteCount,
  output logic                    o_busy,
  output logic                    o_frameValid,
  output logic                    o_timeoutErr
);

  localparam int               c_tmo_w    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_frame    = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND_CMD = 2'd1,
    S_RECV     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_code;
  logic [CNT_W-1:0]     r_byteCount;
  logic [c_tmo_w-1:0]   r_tmo;
  logic                 r_frameValid;
  logic                 r_timeoutErr;
  logic [7:0]           r_rdData;
  logic [7:0]           r_buf [FRAME_BYTES];

  logic w_start;
  logic w_accept;
  logic w_last;
  logic w_tmo_hit;

  assign w_start   = (r_state == S_IDLE) && i_cmdStart && (i_cmdCode != 2'd3);
  assign w_accept  = (r_state == S_RECV) && !i_abort && bus.rxDataAvailable;
  assign w_last    = w_accept && (r_byteCount == c_last_idx);
  // Timeout is armed only after the first byte; the wait for it is unbounded.
  assign w_tmo_hit = (r_state == S_RECV) && !i_abort && !w_accept &&
                     (r_byteCount != '0) && (r_tmo == c_tmo_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    bus.txWrite = 1'b0;
    bus.txData  = 8'h00;
    bus.rxRead  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_SEND_CMD;
      end
      S_SEND_CMD: begin
        case (r_code)
          2'd0:    bus.txData = 8'h63;
          2'd1:    bus.txData = 8'h73;
          default: bus.txData = 8'h6E;
        endcase
        if (i_abort) begin
          w_next = S_IDLE;
        end else if (!bus.txFull) begin
          bus.txWrite = 1'b1;
          w_next      = (r_code == 2'd1) ? S_IDLE : S_RECV;
        end
      end
      S_RECV: begin
        bus.rxRead = w_accept;
        if (i_abort)        w_next = S_IDLE;
        else if (w_last)    w_next = S_DONE;
        else if (w_tmo_hit) w_next = S_IDLE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_code       <= 2'd0;
      r_byteCount  <= '0;
      r_tmo        <= '0;
      r_frameValid <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_rdData     <= 8'h00;
    end else begin
      if (w_start) begin
        r_code       <= i_cmdCode;
        r_byteCount  <= '0;
        r_frameValid <= 1'b0;
        r_timeoutErr <= 1'b0;
      end
      if (w_accept) r_byteCount <= r_byteCount + 1'b1;
      if (w_last)    r_frameValid <= 1'b1;
      if (w_tmo_hit) r_timeoutErr <= 1'b1;

      if (w_accept || w_tmo_hit || (r_state != S_RECV) || (r_byteCount == '0)) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end

      r_rdData <= (i_rdAddr < c_frame) ? r_buf[i_rdAddr] : 8'h00;
    end
  end

  // Frame buffer is deliberately not reset; a read racing a write sees old data.
  always_ff @(posedge clock) begin
    if (w_accept) r_buf[r_byteCount] <= bus.rxData;
  end

  assign o_rdData     = r_rdData;
  assign o_byteCount  = r_byteCount;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frameValid = r_frameValid;
  assign o_timeoutErr = r_timeoutErr;

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_debug_dump_receiver : directed + randomized bench with a byte-stream model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_debug_dump_receiver;
  localparam int FB  = 95;
  localparam int TMO = 16;
  localparam int CW  = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmdStart = 1'b0;
  logic [1:0]    cmdCode = 2'd0;
  logic          abort = 1'b0;
  logic [CW-1:0] rdAddr = '0;
  logic [7:0]    rdData;
  logic [CW-1:0] byteCount;
  logic          busy, frameValid, timeoutErr;

  always #5 clock = ~clock;

  debug_dump_receiver_if bus();

  debug_dump_receiver #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_cmdStart   (cmdStart),
    .i_cmdCode    (cmdCode),
    .i_abort      (abort),
    .bus          (bus),
    .i_rdAddr     (rdAddr),
    .o_rdData     (rdData),
    .o_byteCount  (byteCount),
    .o_busy       (busy),
    .o_frameValid (frameValid),
    .o_timeoutErr (timeoutErr)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rx_mem [128];
  logic [7:0] mbuf   [FB];
  int         rx_len = 0;
  int         rx_idx = 0;
  bit         rx_en = 0;
  bit         rx_rand = 0;
  int         gap_run = 0;
  int         busy_cnt = 0;
  logic       s_rxRead = 1'b0;
  logic [7:0] tx_log [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive the RX source at negedge, observe strobes, advance the model.
  task automatic cyc();
    @(negedge clock);
    if (rx_en && rx_idx < rx_len) begin
      if (rx_rand && gap_run < 6 && $urandom_range(0, 2) == 0) begin
        bus.rxDataAvailable = 1'b0;
        gap_run++;
      end else begin
        bus.rxDataAvailable = 1'b1;
        gap_run = 0;
      end
    end else begin
      bus.rxDataAvailable = 1'b0;
    end
    bus.rxData = (rx_idx < 128) ? rx_mem[rx_idx] : 8'h00;
    #1;
    s_rxRead = bus.rxRead;
    if (busy) busy_cnt++;
    if (bus.txWrite) tx_log.push_back(bus.txData);
    if (bus.rxRead) begin
      if (rx_idx < FB) mbuf[rx_idx] = rx_mem[rx_idx];
      rx_idx++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] code);
    cmdStart = 1'b1;
    cmdCode  = code;
    cyc();
    cmdStart = 1'b0;
  endtask

  task automatic wait_fv(input int budget, input string tag);
    int n = 0;
    while (!frameValid && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(frameValid), 32'd1);
  endtask

  task automatic load_random(input int len);
    for (int i = 0; i < 128; i++) rx_mem[i] = 8'($urandom);
    rx_len = len;
    rx_idx = 0;
  endtask

  initial begin
    int  n;
    bit  rdw_done;
    logic [7:0] lut [3];
    lut[0] = 8'h63; lut[1] = 8'h73; lut[2] = 8'h6E;
    bus.txFull = 1'b0;
    bus.rxDataAvailable = 1'b0;
    bus.rxData = 8'h00;

    // Reset state
    repeat (3) cyc();
    chk("rst_busy",   32'(busy),        32'd0);
    chk("rst_fv",     32'(frameValid),  32'd0);
    chk("rst_tmo",    32'(timeoutErr),  32'd0);
    chk("rst_bc",     32'(byteCount),   32'd0);
    chk("rst_rd",     32'(rdData),      32'd0);
    chk("rst_txw",    32'(bus.txWrite), 32'd0);
    chk("rst_txd",    32'(bus.txData),  32'd0);
    chk("rst_rxr",    32'(bus.rxRead),  32'd0);
    reset = 1'b0;

    // Step-enter: one write of 's', no dump consumed even with RX data pending
    load_random(5);
    rx_en = 1;
    busy_cnt = 0;
    issue(2'd1);
    repeat (3) cyc();
    chk("s_busy_cycles", 32'(busy_cnt),      32'd1);
    chk("s_tx_count",    32'(tx_log.size()), 32'd1);
    chk("s_tx_byte",     32'(tx_log[0]),     32'(lut[1]));
    chk("s_no_pop",      32'(rx_idx),        32'd0);
    chk("s_fv",          32'(frameValid),    32'd0);

    // Next: back-to-back counting bytes, extra bytes must stay in the FIFO
    for (int i = 0; i < 128; i++) rx_mem[i] = 8'(i);
    rx_len = 100;
    rx_idx = 0;
    tx_log.delete();
    issue(2'd2);
    wait_fv(400, "n_frame_valid");
    chk("n_tx_count", 32'(tx_log.size()), 32'd1);
    chk("n_tx_byte",  32'(tx_log[0]),     32'(lut[2]));
    chk("n_bc",       32'(byteCount),     32'(FB));
    chk("n_done_busy", 32'(busy),         32'd1);
    repeat (3) cyc();
    chk("n_pops",     32'(rx_idx),        32'(FB));
    chk("n_fv_sticky", 32'(frameValid),   32'd1);
    chk("n_idle",     32'(busy),          32'd0);
    rdAddr = 7'h2A; cyc();
    chk("n_rd_2a",    32'(rdData),        32'h2A);
    rdAddr = 7'd100; cyc();
    chk("n_rd_oor",   32'(rdData),        32'h00);
    rdAddr = 7'd94; cyc();
    chk("n_rd_last",  32'(rdData),        32'(mbuf[94]));
    rx_en = 0;

    // Continuous: TX back-pressure, long quiet start, random gaps, stray cmdStart
    load_random(FB);
    rx_rand = 1;
    bus.txFull = 1'b1;
    tx_log.delete();
    issue(2'd0);
    repeat (9) cyc();
    chk("c_txfull_hold", 32'(tx_log.size()), 32'd0);
    bus.txFull = 1'b0;
    cyc();
    chk("c_tx_count", 32'(tx_log.size()), 32'd1);
    chk("c_tx_byte",  32'(tx_log[0]),     32'(lut[0]));
    repeat (5000) cyc();
    chk("c_no_tmo_wait", 32'(timeoutErr), 32'd0);
    chk("c_busy_wait",   32'(busy),       32'd1);
    rx_en = 1;
    rdAddr = 7'd50;
    n = 0;
    rdw_done = 0;
    while (!frameValid && n < 1500) begin
      if (n == 20) cmdStart = 1'b1;
      cmdCode = 2'd1;
      cyc();
      cmdStart = 1'b0;
      if (!rdw_done && s_rxRead && rx_idx == 51) begin
        chk("c_rd_during_wr", 32'(rdData), 32'h32);
        rdw_done = 1;
      end
      n++;
    end
    chk("c_frame_valid", 32'(frameValid),   32'd1);
    chk("c_rdw_seen",    32'(rdw_done),     32'd1);
    chk("c_no_extra_tx", 32'(tx_log.size()), 32'd1);
    chk("c_tmo",         32'(timeoutErr),   32'd0);
    chk("c_bc",          32'(byteCount),    32'(FB));
    cyc();
    chk("c_rd_new50",    32'(rdData),       32'(rx_mem[50]));
    for (int i = 0; i < FB; i++) begin
      rdAddr = CW'(i);
      cyc();
      chk($sformatf("c_rd_%0d", i), 32'(rdData), 32'(mbuf[i]));
    end
    rdAddr = 7'd127; cyc();
    chk("c_rd_oor", 32'(rdData), 32'h00);
    rx_rand = 0;

    // Inter-byte timeout after a partial frame
    load_random(40);
    issue(2'd2);
    chk("t_fv_cleared", 32'(frameValid), 32'd0);
    n = 0;
    while (rx_idx < 40 && n < 500) begin cyc(); n++; end
    n = 0;
    while (!timeoutErr && n < 100) begin cyc(); n++; end
    chk("t_delay",  32'(n),          32'(TMO));
    chk("t_bc",     32'(byteCount),  32'd40);
    chk("t_fv",     32'(frameValid), 32'd0);
    chk("t_idle",   32'(busy),       32'd0);
    rdAddr = 7'd39; cyc();
    chk("t_rd_39",  32'(rdData),     32'(mbuf[39]));
    rdAddr = 7'd40; cyc();
    chk("t_rd_40_old", 32'(rdData),  32'(mbuf[40]));

    // Abort coinciding with the final byte
    load_random(FB);
    issue(2'd2);
    chk("a_tmo_cleared", 32'(timeoutErr), 32'd0);
    n = 0;
    while (rx_idx < FB - 1 && n < 500) begin cyc(); n++; end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("a_no_pop", 32'(s_rxRead),  32'd0);
    chk("a_bc",     32'(byteCount), 32'(FB - 1));
    chk("a_fv",     32'(frameValid), 32'd0);
    chk("a_idle",   32'(busy),      32'd0);
    rx_en = 0;
    tx_log.delete();
    issue(2'd3);
    cyc();
    chk("r3_busy",  32'(busy),          32'd0);
    chk("r3_bc",    32'(byteCount),     32'(FB - 1));
    chk("r3_tx",    32'(tx_log.size()), 32'd0);
    issue(2'd1);
    chk("a_restart_bc", 32'(byteCount), 32'd0);
    repeat (2) cyc();

    // Abort while the command is still pending
    tx_log.delete();
    issue(2'd2);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("as_no_tx", 32'(tx_log.size()), 32'd0);
    chk("as_idle",  32'(busy),          32'd0);

    // Reset in the middle of reception
    load_random(FB);
    rx_en = 1;
    issue(2'd0);
    repeat (20) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mr_busy", 32'(busy),       32'd0);
    chk("mr_bc",   32'(byteCount),  32'd0);
    chk("mr_fv",   32'(frameValid), 32'd0);
    cyc();
    chk("mr_no_pop", 32'(s_rxRead), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
